// File: rtl/ibex_loader_pkg.sv
// Shared types and constants for the instruction-ROM program loader.
package ibex_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        SUM,
        DONE,
        ERR
    } loader_state_e;

    localparam logic [3:0]  BE_FULL    = 4'hF;
    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned WORD_W     = 8 * WORD_BYTES;

endpackage

// File: rtl/ibex_loader_word_asm.sv
// Assembles accepted bytes LSB-first into words; word_c/word_valid_c are valid
// combinationally in the cycle the final byte of a word is accepted.
module ibex_loader_word_asm
    import ibex_loader_pkg::*;
(
    input  logic              clk_sys,
    input  logic              rst_sys_n,
    input  logic              clr,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word_c,
    output logic              word_valid_c
);

    localparam int unsigned CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0]  cnt_q;
    logic [WORD_W-9:0] part_q;

    // Byte counter wraps naturally after the last byte; partial bytes persist across gaps
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            cnt_q  <= '0;
            part_q <= '0;
        end else if (clr) begin
            cnt_q  <= '0;
        end else if (byte_valid) begin
            cnt_q <= cnt_q + CNT_W'(1);
            for (int k = 0; k < int'(WORD_BYTES) - 1; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    part_q[8*k +: 8] <= byte_data;
                end
            end
        end
    end

    assign word_c       = {byte_data, part_q};
    assign word_valid_c = byte_valid && (cnt_q == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/ibex_prog_loader.sv
// Loads a framed image (LEN, payload words, SUM) into the instruction ROM and
// releases the core from reset only once the checksum matches.
module ibex_prog_loader
    import ibex_loader_pkg::*;
#(
    parameter logic [31:0]  BASE_ADDR = 32'h0000_0000,
    parameter int unsigned  MAX_WORDS = 1024
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,
    input  logic        start_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        instr_we,
    output logic [3:0]  instr_be,
    output logic [31:0] instr_wdata,
    output logic [31:0] instr_waddr,
    output logic        core_rst_no,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

    loader_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, len_q;
    logic [31:0]       sum_q;
    logic              ready_d, done_d, err_d;
    logic              byte_acc_c, start_acc_c;
    logic [WORD_W-1:0] word_c;
    logic              word_valid_c;

    assign byte_acc_c  = in_valid_i && in_ready_o;
    assign start_acc_c = start_i && (state_q inside {IDLE, DONE, ERR});

    ibex_loader_word_asm u_word_asm (
        .clk_sys      (clk_sys),
        .rst_sys_n    (rst_sys_n),
        .clr          (start_acc_c),
        .byte_valid   (byte_acc_c),
        .byte_data    (in_data_i),
        .word_c       (word_c),
        .word_valid_c (word_valid_c)
    );

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_acc_c) state_d = LEN;
            end
            LEN: begin
                if (word_valid_c) begin
                    if (word_c > 32'(MAX_WORDS))  state_d = ERR;
                    else if (word_c == '0)        state_d = SUM;
                    else                          state_d = DATA;
                end
            end
            DATA: begin
                if (word_valid_c && (idx_q == len_q - IDX_W'(1))) state_d = SUM;
            end
            SUM: begin
                if (word_valid_c) state_d = (word_c == sum_q) ? DONE : ERR;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d inside {LEN, DATA, SUM};
        done_d  = (state_d == DONE);
        err_d   = (state_d == ERR);
    end

    // Registered ROM port, status outputs and payload bookkeeping
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            idx_q       <= '0;
            len_q       <= '0;
            sum_q       <= '0;
            instr_we    <= 1'b0;
            instr_be    <= '0;
            instr_wdata <= '0;
            instr_waddr <= BASE_ADDR;
            in_ready_o  <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            core_rst_no <= 1'b0;
        end else begin
            instr_we    <= 1'b0;
            instr_be    <= '0;
            in_ready_o  <= ready_d;
            done_o      <= done_d;
            err_o       <= err_d;
            core_rst_no <= done_d;
            if (start_acc_c || (state_q == LEN && word_valid_c)) begin
                idx_q <= '0;
                sum_q <= '0;
            end
            if (state_q == LEN && word_valid_c) begin
                len_q <= IDX_W'(word_c);
            end
            if (state_q == DATA && word_valid_c) begin
                instr_we    <= 1'b1;
                instr_be    <= BE_FULL;
                instr_wdata <= word_c;
                instr_waddr <= BASE_ADDR + (32'(idx_q) << 2);
                sum_q       <= sum_q + word_c;
                idx_q       <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule
